// File: rtl/recon_sequencer_if.sv
// Sequencer <-> reconstruction datapath handshake.
// Master drives start/clock-enable/sample, slave returns the result strobe.
interface recon_sequencer_if #(
   parameter int ADC_WIDTH = 12,
   parameter int DAC_WIDTH = 32
);
   logic                        recon_start;
   logic                        recon_clk_en;
   logic [ADC_WIDTH-1:0]        recon_adc_in;
   logic                        recon_valid;
   logic signed [DAC_WIDTH-1:0] recon_dout;

   modport master (
      output recon_start,
      output recon_clk_en,
      output recon_adc_in,
      input  recon_valid,
      input  recon_dout
   );

   modport slave (
      input  recon_start,
      input  recon_clk_en,
      input  recon_adc_in,
      output recon_valid,
      output recon_dout
   );
endinterface

// File: rtl/recon_sequencer.sv
// Periodic sample scheduler for a modulo-ADC reconstruction datapath.
// Issues start, waits for the result (with timeout), flushes, then idles.
module recon_sequencer #(
   parameter int ADC_WIDTH     = 12,
   parameter int DAC_WIDTH     = 32,
   parameter int SAMPLE_PERIOD = 72,
   parameter int TIMEOUT       = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic                        clear_err,
   input  logic [ADC_WIDTH-1:0]        adc_data,
   recon_sequencer_if.master           recon,
   output logic signed [DAC_WIDTH-1:0] dac_data,
   output logic                        dac_load,
   output logic                        busy,
   output logic                        timeout_err,
   output logic [7:0]                  miss_count
);

   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      GAP
   } state_t;

   state_t state;
   state_t next_state;

   logic [TW-1:0] timer;
   logic          tick;
   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] wait_d;
   logic          wait_to;
   logic          accept;

   logic                        start_q, start_d;
   logic                        clk_en_q, clk_en_d;
   logic [ADC_WIDTH-1:0]        adc_q, adc_d;
   logic signed [DAC_WIDTH-1:0] dac_q, dac_d;
   logic                        load_q, load_d;
   logic                        busy_q, busy_d;
   logic                        terr_q, terr_d;
   logic [7:0]                  miss_q, miss_d;

   assign tick    = enable && (timer == T_LAST);
   assign wait_to = (wait_cnt == W_LAST);
   assign accept  = (state == WAIT) && recon.recon_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         timer <= '0;
      else if (!enable || tick)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (tick) next_state = START;
         START:   next_state = WAIT;
         WAIT:    if (recon.recon_valid || wait_to) next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from next_state so the registered copy lines up
   // with the state register.
   always_comb begin
      start_d  = (next_state == START);
      clk_en_d = (next_state == START) || (next_state == WAIT);
      busy_d   = (next_state != IDLE);
      adc_d    = (state == IDLE && tick) ? adc_data : adc_q;
      load_d   = accept;
      dac_d    = accept ? recon.recon_dout : dac_q;
      wait_d   = (state == WAIT) ? wait_cnt + 1'b1 : '0;
      terr_d   = terr_q;
      if (state == WAIT && !recon.recon_valid && wait_to)
         terr_d = 1'b1;
      else if (clear_err)
         terr_d = 1'b0;
      miss_d = miss_q;
      if (tick && state != IDLE)
         miss_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
      else if (clear_err)
         miss_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q  <= 1'b0;
         clk_en_q <= 1'b0;
         adc_q    <= '0;
         dac_q    <= '0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
         miss_q   <= '0;
         wait_cnt <= '0;
      end else begin
         start_q  <= start_d;
         clk_en_q <= clk_en_d;
         adc_q    <= adc_d;
         dac_q    <= dac_d;
         load_q   <= load_d;
         busy_q   <= busy_d;
         terr_q   <= terr_d;
         miss_q   <= miss_d;
         wait_cnt <= wait_d;
      end
   end

   assign recon.recon_start  = start_q;
   assign recon.recon_clk_en = clk_en_q;
   assign recon.recon_adc_in = adc_q;
   assign dac_data           = dac_q;
   assign dac_load           = load_q;
   assign busy               = busy_q;
   assign timeout_err        = terr_q;
   assign miss_count         = miss_q;

endmodule

// File: tb/tb_recon_sequencer.sv
// Directed bench for recon_sequencer: default-period instance plus a
// short-period instance for miss-count saturation.
module tb_recon_sequencer;
   localparam int AW = 12;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset_n;
   logic enable, clear_err;
   logic [AW-1:0] adc_data;
   logic signed [DW-1:0] dac_data;
   logic dac_load, busy, timeout_err;
   logic [7:0] miss_count;

   logic f_enable;
   logic signed [DW-1:0] f_dac_data;
   logic f_dac_load, f_busy, f_timeout_err;
   logic [7:0] f_miss_count;

   int errors = 0;
   int checks = 0;

   recon_sequencer_if #(.ADC_WIDTH(AW), .DAC_WIDTH(DW)) dp ();
   recon_sequencer_if #(.ADC_WIDTH(AW), .DAC_WIDTH(DW)) fdp ();

   recon_sequencer #(
      .ADC_WIDTH(AW), .DAC_WIDTH(DW),
      .SAMPLE_PERIOD(72), .TIMEOUT(64)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .enable(enable), .clear_err(clear_err),
      .adc_data(adc_data), .recon(dp.master),
      .dac_data(dac_data), .dac_load(dac_load),
      .busy(busy), .timeout_err(timeout_err),
      .miss_count(miss_count)
   );

   recon_sequencer #(
      .ADC_WIDTH(AW), .DAC_WIDTH(DW),
      .SAMPLE_PERIOD(8), .TIMEOUT(64)
   ) u_fast (
      .clk(clk), .reset_n(reset_n),
      .enable(f_enable), .clear_err(1'b0),
      .adc_data(12'd5), .recon(fdp.master),
      .dac_data(f_dac_data), .dac_load(f_dac_load),
      .busy(f_busy), .timeout_err(f_timeout_err),
      .miss_count(f_miss_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      while (dp.recon_start !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (dp.recon_start !== 1'b1) begin
         errors++;
         $display("FAIL wait_start: recon_start=%b after %0d cycles, want 1",
                  dp.recon_start, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      clear_err = 1'b0;
      adc_data = '0;
      f_enable = 1'b0;
      dp.recon_valid = 1'b0;
      dp.recon_dout = '0;
      fdp.recon_valid = 1'b0;
      fdp.recon_dout = '0;
      repeat (3) step();
      checks++;
      if ({dp.recon_start, dp.recon_clk_en, dac_load, busy, timeout_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {dp.recon_start, dp.recon_clk_en, dac_load, busy, timeout_err});
      end
      checks++;
      if (dp.recon_adc_in !== 12'd0 || dac_data !== 32'sd0 || miss_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_data: adc_in=%0d dac=%h miss=%0d want 0",
                  dp.recon_adc_in, dac_data, miss_count);
      end
      checks++;
      if (f_busy !== 1'b0 || f_miss_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_fast: busy=%b miss=%0d want 0", f_busy, f_miss_count);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      int early = 0;
      adc_data = 12'd1000;
      enable = 1'b1;
      for (int i = 1; i <= 71; i++) begin
         step();
         if (dp.recon_start === 1'b1) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL start_early: %0d starts before cycle 72, want 0", early);
      end
      step();
      checks++;
      if (dp.recon_start !== 1'b1) begin
         errors++;
         $display("FAIL start_cycle72: recon_start=%b want 1", dp.recon_start);
      end
      checks++;
      if (dp.recon_adc_in !== 12'd1000 || dp.recon_clk_en !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_outputs: adc_in=%0d clk_en=%b busy=%b want 1000 1 1",
                  dp.recon_adc_in, dp.recon_clk_en, busy);
      end
      step();
      checks++;
      if (dp.recon_start !== 1'b0 || dp.recon_clk_en !== 1'b1) begin
         errors++;
         $display("FAIL wait_entry: start=%b clk_en=%b want 0 1",
                  dp.recon_start, dp.recon_clk_en);
      end
      repeat (7) step();
      adc_data = 12'd77;
      repeat (12) step();
      checks++;
      if (dp.recon_adc_in !== 12'd1000) begin
         errors++;
         $display("FAIL adc_hold: adc_in=%0d want 1000", dp.recon_adc_in);
      end
      dp.recon_valid = 1'b1;
      dp.recon_dout = 32'h0000_1234;
      checks++;
      if (dac_load !== 1'b0) begin
         errors++;
         $display("FAIL load_early: dac_load=%b want 0", dac_load);
      end
      step();
      dp.recon_valid = 1'b0;
      dp.recon_dout = '0;
      checks++;
      if (dac_load !== 1'b1 || dac_data !== 32'sh1234 || dp.recon_clk_en !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gap: load=%b dac=%h clk_en=%b busy=%b want 1 00001234 0 1",
                  dac_load, dac_data, dp.recon_clk_en, busy);
      end
      step();
      checks++;
      if (dac_load !== 1'b0 || busy !== 1'b0 || dac_data !== 32'sh1234) begin
         errors++;
         $display("FAIL idle_after: load=%b busy=%b dac=%h want 0 0 00001234",
                  dac_load, busy, dac_data);
      end
   endtask

   task automatic test_timeout();
      int loads = 0;
      wait_start(200);
      for (int j = 1; j <= 64; j++) begin
         step();
         if (dac_load === 1'b1) loads++;
      end
      checks++;
      if (timeout_err !== 1'b0 || dp.recon_clk_en !== 1'b1) begin
         errors++;
         $display("FAIL wait64: terr=%b clk_en=%b want 0 1", timeout_err, dp.recon_clk_en);
      end
      step();
      checks++;
      if (timeout_err !== 1'b1 || dac_load !== 1'b0 || loads != 0) begin
         errors++;
         $display("FAIL timeout_set: terr=%b load=%b loads=%0d want 1 0 0",
                  timeout_err, dac_load, loads);
      end
      checks++;
      if (dac_data !== 32'sh1234 || dp.recon_clk_en !== 1'b0 || miss_count !== 8'd0) begin
         errors++;
         $display("FAIL timeout_hold: dac=%h clk_en=%b miss=%0d want 00001234 0 0",
                  dac_data, dp.recon_clk_en, miss_count);
      end
   endtask

   task automatic test_clear_and_valid_at_timeout();
      wait_start(200);
      step();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checks++;
      if (timeout_err !== 1'b0 || miss_count !== 8'd0) begin
         errors++;
         $display("FAIL clear_err: terr=%b miss=%0d want 0 0", timeout_err, miss_count);
      end
      repeat (62) step();
      dp.recon_valid = 1'b1;
      dp.recon_dout = 32'hFFFF_FFF0;
      step();
      dp.recon_dout = 32'h0000_ABCD;
      checks++;
      if (dac_load !== 1'b1 || dac_data !== -32'sd16 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL valid_wins: load=%b dac=%h terr=%b want 1 fffffff0 0",
                  dac_load, dac_data, timeout_err);
      end
      step();
      step();
      dp.recon_valid = 1'b0;
      checks++;
      if (dac_load !== 1'b0 || dac_data !== -32'sd16) begin
         errors++;
         $display("FAIL valid_ignored: load=%b dac=%h want 0 fffffff0", dac_load, dac_data);
      end
   endtask

   task automatic test_enable_drop();
      int starts = 0;
      wait_start(200);
      step();
      step();
      enable = 1'b0;
      repeat (5) step();
      dp.recon_valid = 1'b1;
      dp.recon_dout = 32'h0000_0055;
      step();
      dp.recon_valid = 1'b0;
      checks++;
      if (dac_load !== 1'b1 || dac_data !== 32'sh55 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_load: load=%b dac=%h busy=%b want 1 00000055 1",
                  dac_load, dac_data, busy);
      end
      for (int i = 0; i < 200; i++) begin
         step();
         if (dp.recon_start === 1'b1) starts++;
      end
      checks++;
      if (starts != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_idle: starts=%0d busy=%b want 0 0", starts, busy);
      end
   endtask

   task automatic test_reset_mid();
      int loads = 0;
      int early = 0;
      enable = 1'b1;
      wait_start(100);
      repeat (3) step();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({dp.recon_start, dp.recon_clk_en, dac_load, busy, timeout_err} !== 5'b0) begin
         errors++;
         $display("FAIL async_flags: got %b want 00000",
                  {dp.recon_start, dp.recon_clk_en, dac_load, busy, timeout_err});
      end
      checks++;
      if (dp.recon_adc_in !== 12'd0 || dac_data !== 32'sd0 || miss_count !== 8'd0) begin
         errors++;
         $display("FAIL async_data: adc_in=%0d dac=%h miss=%0d want 0",
                  dp.recon_adc_in, dac_data, miss_count);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      dp.recon_valid = 1'b1;
      dp.recon_dout = 32'h0000_0999;
      for (int i = 1; i <= 71; i++) begin
         step();
         if (i == 3) dp.recon_valid = 1'b0;
         if (dac_load === 1'b1) loads++;
         if (dp.recon_start === 1'b1) early++;
      end
      checks++;
      if (loads != 0 || dac_data !== 32'sd0 || early != 0) begin
         errors++;
         $display("FAIL late_valid: loads=%0d dac=%h early=%0d want 0 0 0",
                  loads, dac_data, early);
      end
      step();
      checks++;
      if (dp.recon_start !== 1'b1) begin
         errors++;
         $display("FAIL restart72: recon_start=%b want 1", dp.recon_start);
      end
      enable = 1'b0;
   endtask

   task automatic test_miss_saturation();
      f_enable = 1'b1;
      for (int k = 1; k <= 2700; k++) begin
         step();
         if (k == 74) begin
            checks++;
            if (f_timeout_err !== 1'b1 || f_dac_load !== 1'b0) begin
               errors++;
               $display("FAIL fast_timeout: terr=%b load=%b want 1 0",
                        f_timeout_err, f_dac_load);
            end
         end
         if (k == 75) begin
            checks++;
            if (f_miss_count !== 8'd8 || f_busy !== 1'b0) begin
               errors++;
               $display("FAIL fast_miss8: miss=%0d busy=%b want 8 0",
                        f_miss_count, f_busy);
            end
         end
         if (k == 80) begin
            checks++;
            if (fdp.recon_start !== 1'b1) begin
               errors++;
               $display("FAIL fast_restart: start=%b want 1", fdp.recon_start);
            end
         end
         if (k == 2500 || k == 2700) begin
            checks++;
            if (f_miss_count !== 8'd255) begin
               errors++;
               $display("FAIL fast_sat_%0d: miss=%0d want 255", k, f_miss_count);
            end
         end
      end
      f_enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_clear_and_valid_at_timeout();
      test_enable_drop();
      test_reset_mid();
      test_miss_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
